reg_write_sched: RTL and testbench

- Write-port scheduler in front of the 16-entry register file.
- Shares the file's single write port between three requesters:
  - the core writeback path;
  - the program/data loader port, using a req/gnt handshake;
  - a sequenced clear engine that zeroes every register, one per cycle.
- Drives the register file's write enable, address and data directly. Stalls the core when the core loses arbitration.

---
 rtl/reg_write_sched.sv | 128 ++++++++++++
 tb/tb_reg_write_sched.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_sched.sv
// Write-port scheduler for a 2**D-entry register file: arbitrates the core
// writeback, a req/gnt loader with starvation relief, and a sequenced clear.
module reg_write_sched #(
   parameter int W      = 8,
   parameter int D      = 4,
   parameter int STARVE = 4
) (
   input  logic         CLK,
   input  logic         reset,
   input  logic         clr_start,
   input  logic         wb_en,
   input  logic [D-1:0] wb_addr,
   input  logic [W-1:0] wb_data,
   input  logic         ld_req,
   input  logic [D-1:0] ld_addr,
   input  logic [W-1:0] ld_data,
   output logic         ld_gnt,
   output logic         core_stall,
   output logic         wr_en,
   output logic [D-1:0] wr_addr,
   output logic [W-1:0] wr_data,
   output logic         busy,
   output logic         clr_done
);

   localparam int SW = $clog2(STARVE + 1);
   localparam logic [D-1:0]  LAST_ADDR  = {D{1'b1}};
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic [D-1:0]  clr_ptr_q, clr_ptr_d;
   logic [SW-1:0] starve_cnt_q, starve_cnt_d;

   // Port arbitration; every output is forced low while reset is asserted.
   always_comb begin
      ld_gnt     = 1'b0;
      core_stall = 1'b0;
      wr_en      = 1'b0;
      wr_addr    = {D{1'b0}};
      wr_data    = {W{1'b0}};
      busy       = 1'b0;
      clr_done   = 1'b0;
      if (!reset) begin
         ld_gnt = 1'b0;
      end else if (state_q == CLEAR) begin
         wr_en      = 1'b1;
         wr_addr    = clr_ptr_q;
         core_stall = wb_en;
         busy       = 1'b1;
         clr_done   = (clr_ptr_q == LAST_ADDR);
      end else if (ld_req && (starve_cnt_q == STARVE_MAX)) begin
         // A starved loader is forced ahead of the core.
         ld_gnt     = 1'b1;
         wr_en      = 1'b1;
         wr_addr    = ld_addr;
         wr_data    = ld_data;
         core_stall = wb_en;
      end else if (wb_en) begin
         wr_en   = 1'b1;
         wr_addr = wb_addr;
         wr_data = wb_data;
      end else if (ld_req) begin
         ld_gnt  = 1'b1;
         wr_en   = 1'b1;
         wr_addr = ld_addr;
         wr_data = ld_data;
      end else begin
         wr_en = 1'b0;
      end
   end

   // Next-state for the clear sequencer and the loader wait counter.
   always_comb begin
      state_d      = state_q;
      clr_ptr_d    = clr_ptr_q;
      starve_cnt_d = starve_cnt_q;
      case (state_q)
         IDLE: begin
            if (ld_gnt || !ld_req) begin
               starve_cnt_d = {SW{1'b0}};
            end else if (starve_cnt_q < STARVE_MAX) begin
               starve_cnt_d = starve_cnt_q + {{(SW-1){1'b0}}, 1'b1};
            end else begin
               starve_cnt_d = starve_cnt_q;
            end
            if (clr_start) begin
               state_d   = CLEAR;
               clr_ptr_d = {D{1'b0}};
            end else begin
               state_d = IDLE;
            end
         end
         CLEAR: begin
            // starve_cnt stays frozen so a pending loader resumes its wait.
            if (clr_ptr_q == LAST_ADDR) begin
               state_d   = IDLE;
               clr_ptr_d = {D{1'b0}};
            end else begin
               clr_ptr_d = clr_ptr_q + {{(D-1){1'b0}}, 1'b1};
            end
         end
         default: begin
            state_d      = IDLE;
            clr_ptr_d    = {D{1'b0}};
            starve_cnt_d = {SW{1'b0}};
         end
      endcase
   end

   // State registers.
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         clr_ptr_q    <= {D{1'b0}};
         starve_cnt_q <= {SW{1'b0}};
      end else begin
         state_q      <= state_d;
         clr_ptr_q    <= clr_ptr_d;
         starve_cnt_q <= starve_cnt_d;
      end
   end

endmodule

// File: tb/tb_reg_write_sched.sv
// Bench for reg_write_sched: directed plan steps followed by randomized
// traffic, all checked against a cycle-level reference model.
module tb_reg_write_sched;

   localparam int W = 8, D = 4, STARVE = 4, NREG = 16;

   logic         CLK = 1'b0;
   logic         reset, clr_start, wb_en, ld_req;
   logic [D-1:0] wb_addr, ld_addr, wr_addr;
   logic [W-1:0] wb_data, ld_data, wr_data;
   logic         ld_gnt, core_stall, wr_en, busy, clr_done;

   int checks = 0;
   int errors = 0;

   // Reference model state: clear cycles remaining and loader denied-cycle count.
   int clr_left = 0;
   int wait_cnt = 0;
   logic         e_gnt, e_stall, e_wen, e_busy, e_done;
   logic [D-1:0] e_addr;
   logic [W-1:0] e_data;

   always #5 CLK = ~CLK;

   reg_write_sched #(.W(W), .D(D), .STARVE(STARVE)) dut (
      .CLK(CLK), .reset(reset), .clr_start(clr_start),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data),
      .ld_gnt(ld_gnt), .core_stall(core_stall),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy(busy), .clr_done(clr_done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic predict();
      {e_gnt, e_stall, e_wen, e_busy, e_done} = 5'b0;
      e_addr = '0;
      e_data = '0;
      if (!reset) begin
         e_wen = 1'b0;
      end else if (clr_left > 0) begin
         e_wen   = 1'b1;
         e_addr  = D'(NREG - clr_left);
         e_stall = wb_en;
         e_busy  = 1'b1;
         e_done  = (clr_left == 1);
      end else if (ld_req && (wait_cnt >= STARVE || !wb_en)) begin
         e_gnt   = 1'b1;
         e_wen   = 1'b1;
         e_addr  = ld_addr;
         e_data  = ld_data;
         e_stall = wb_en;
      end else if (wb_en) begin
         e_wen  = 1'b1;
         e_addr = wb_addr;
         e_data = wb_data;
      end
   endtask

   task automatic check_all();
      predict();
      chk("ld_gnt",     32'(ld_gnt),     32'(e_gnt));
      chk("core_stall", 32'(core_stall), 32'(e_stall));
      chk("wr_en",      32'(wr_en),      32'(e_wen));
      chk("wr_addr",    32'(wr_addr),    32'(e_addr));
      chk("wr_data",    32'(wr_data),    32'(e_data));
      chk("busy",       32'(busy),       32'(e_busy));
      chk("clr_done",   32'(clr_done),   32'(e_done));
   endtask

   task automatic advance();
      @(posedge CLK);
      if (!reset) begin
         clr_left = 0;
         wait_cnt = 0;
      end else if (clr_left > 0) begin
         clr_left--;
      end else begin
         if (clr_start) clr_left = NREG;
         if (ld_req && !e_gnt) wait_cnt = (wait_cnt < STARVE) ? wait_cnt + 1 : STARVE;
         else wait_cnt = 0;
      end
      @(negedge CLK);
   endtask

   task automatic tick();
      #1;
      check_all();
      advance();
   endtask

   task automatic idle_inputs();
      clr_start = 1'b0;
      wb_en = 1'b0; wb_addr = '0; wb_data = '0;
      ld_req = 1'b0; ld_addr = '0; ld_data = '0;
   endtask

   initial begin
      int done_at;
      reset = 1'b0;
      idle_inputs();
      @(negedge CLK);
      tick();
      tick();
      reset = 1'b1;

      // 1: single core write
      wb_en = 1'b1; wb_addr = 4'd3; wb_data = 8'hA5;
      #1;
      check_all();
      chk("t1_wr_addr", 32'(wr_addr), 32'd3);
      chk("t1_wr_data", 32'(wr_data), 32'hA5);
      advance();

      // 2: loader starved by a busy core, then forced ahead
      ld_req = 1'b1; ld_addr = 4'd7; ld_data = 8'h3C;
      for (int i = 0; i < 6; i++) begin
         wb_en = 1'b1; wb_addr = 4'(i); wb_data = 8'(8'h10 + i);
         #1;
         check_all();
         if (i < 4) chk("t2_denied", 32'(ld_gnt), 32'd0);
         if (i == 4) begin
            chk("t2_gnt", 32'(ld_gnt), 32'd1);
            chk("t2_addr", 32'(wr_addr), 32'd7);
            chk("t2_stall", 32'(core_stall), 32'd1);
         end
         if (i == 5) chk("t2_core_back", 32'(core_stall), 32'd0);
         advance();
         if (i == 4) ld_req = 1'b0;
      end
      idle_inputs();
      tick();

      // 3: full clear with idle inputs
      clr_start = 1'b1;
      tick();
      clr_start = 1'b0;
      for (int i = 0; i < NREG; i++) begin
         #1;
         check_all();
         chk("t3_addr", 32'(wr_addr), 32'(i));
         chk("t3_done", 32'(clr_done), 32'(i == NREG - 1));
         advance();
      end
      #1;
      check_all();
      chk("t3_busy_after", 32'(busy), 32'd0);
      advance();

      // 4: core and loader both waiting across a clear
      wb_en = 1'b1; wb_addr = 4'd12; wb_data = 8'h9E;
      ld_req = 1'b1; ld_addr = 4'd9; ld_data = 8'h55;
      clr_start = 1'b1;
      tick();
      clr_start = 1'b0;
      for (int i = 0; i < NREG; i++) begin
         #1;
         check_all();
         chk("t4_stall", 32'(core_stall), 32'd1);
         advance();
      end
      #1;
      check_all();
      chk("t4_core_first", 32'(wr_addr), 32'd12);
      advance();
      wb_en = 1'b0;
      #1;
      check_all();
      chk("t4_ld_gnt", 32'(ld_gnt), 32'd1);
      advance();
      idle_inputs();

      // 5: second clr_start mid-clear is ignored
      clr_start = 1'b1;
      tick();
      clr_start = 1'b0;
      done_at = 0;
      for (int i = 1; i <= NREG + 4; i++) begin
         clr_start = (i == 5);
         #1;
         check_all();
         if (clr_done === 1'b1) done_at = i;
         advance();
      end
      clr_start = 1'b0;
      chk("t5_done_cycle", 32'(done_at), 32'd16);

      // 6: asynchronous reset in the middle of a clear
      clr_start = 1'b1;
      tick();
      clr_start = 1'b0;
      for (int i = 1; i < 8; i++) tick();
      reset = 1'b0;
      #1;
      check_all();
      chk("t6_busy_rst", 32'(busy), 32'd0);
      chk("t6_wen_rst", 32'(wr_en), 32'd0);
      #1;
      reset = 1'b1;
      clr_left = 0;
      wait_cnt = 0;
      advance();
      for (int i = 0; i < 3; i++) tick();
      clr_start = 1'b1;
      tick();
      clr_start = 1'b0;
      #1;
      check_all();
      chk("t6_restart_addr", 32'(wr_addr), 32'd0);
      chk("t6_restart_busy", 32'(busy), 32'd1);
      advance();

      // Randomized traffic with loader/core retry protocols
      for (int n = 0; n < 1500; n++) begin
         logic hold_core, hold_ld;
         hold_core = wb_en && e_stall && reset;
         hold_ld   = ld_req && !e_gnt && reset;
         reset     = ($urandom_range(0, 250) != 0);
         clr_start = ($urandom_range(0, 40) == 0);
         if (!hold_core) begin
            wb_en   = ($urandom_range(0, 2) != 0);
            wb_addr = 4'($urandom);
            wb_data = 8'($urandom);
         end
         if (!hold_ld) begin
            ld_req  = ($urandom_range(0, 2) == 0);
            ld_addr = 4'($urandom);
            ld_data = 8'($urandom);
         end
         tick();
      end
      reset = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
